// File: rtl/motor_pkg.sv
// motor_pkg: shared mode codes, bridge direction encoding and wheel state enum for the motor mode driver.
package motor_pkg;
   typedef enum logic [4:0] {
      M_IDLE     = 5'd0,
      M_START    = 5'd1,
      M_COUNT    = 5'd2,
      M_STRAIGHT = 5'd3,
      M_CHOOSE   = 5'd4,
      M_TURN_L   = 5'd5,
      M_TURN_R   = 5'd6,
      M_BACK     = 5'd7,
      M_STOP     = 5'd30,
      M_ERROR    = 5'd31
   } mode_e;
   // Encoding matches the bridge pins directly: {IN1,IN2}.
   typedef enum logic [1:0] {
      DIR_OFF = 2'b00,
      DIR_REV = 2'b01,
      DIR_FWD = 2'b10
   } dir_e;
   typedef enum logic [1:0] {
      W_OFF,
      W_RUN,
      W_DECEL,
      W_DEAD
   } wstate_e;
endpackage

// File: rtl/wheel_channel.sv
// wheel_channel: per-wheel direction FSM with duty soft-ramp, reversal dead-time, wrap-latched PWM duty and bridge pins.
module wheel_channel
   import motor_pkg::*;
#(
   parameter int DUTY_W     = 11,
   parameter int PWM_PERIOD = 1024,
   parameter int RAMP_STEP  = 32,
   parameter int DEAD_CYC   = 50000,
   parameter int CW         = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_i,
   input  logic              wrap_i,
   input  logic              estop_i,
   input  logic [CW-1:0]     cnt_i,
   input  dir_e              tgt_dir_i,
   input  logic [DUTY_W-1:0] tgt_duty_i,
   output logic              pwm_o,
   output logic [1:0]        in_o,
   output logic              settled_o
);
   localparam int DCW = DEAD_CYC > 1 ? $clog2(DEAD_CYC) : 1;
   wstate_e st_q, st_d;
   dir_e dir_q, dir_d;
   logic [DUTY_W-1:0] cur_q, cur_d, app_q, app_d, goal, diff, stp, ramped;
   logic [DCW-1:0] dead_q, dead_d;
   logic active, dead_done;
   assign active    = st_q == W_RUN || st_q == W_DECEL;
   assign dead_done = dead_q == DCW'(DEAD_CYC - 1);
   // Ramp only toward the commanded duty while still driving the matching direction; otherwise head for zero.
   always_comb begin
      goal   = (active && tgt_dir_i == dir_q) ? tgt_duty_i : '0;
      diff   = goal > cur_q ? goal - cur_q : cur_q - goal;
      stp    = diff > DUTY_W'(RAMP_STEP) ? DUTY_W'(RAMP_STEP) : diff;
      ramped = goal > cur_q ? cur_q + stp : cur_q - stp;
   end
   always_comb begin
      st_d   = st_q;
      dir_d  = dir_q;
      dead_d = '0;
      cur_d  = tick_i ? ramped : cur_q;
      app_d  = wrap_i ? cur_q : app_q;
      if (estop_i) begin
         st_d  = W_OFF;
         dir_d = DIR_OFF;
         cur_d = '0;
         app_d = '0;
      end else begin
         case (st_q)
            W_OFF: if (tgt_dir_i != DIR_OFF) begin
               st_d  = W_RUN;
               dir_d = tgt_dir_i;
            end
            W_RUN: if (tgt_dir_i != dir_q) st_d = W_DECEL;
            W_DECEL: if (tgt_dir_i == dir_q) st_d = W_RUN;
               else if (cur_q == '0) st_d = tgt_dir_i == DIR_OFF ? W_OFF : W_DEAD;
            W_DEAD: if (dead_done) begin
               st_d  = tgt_dir_i == DIR_OFF ? W_OFF : W_RUN;
               dir_d = tgt_dir_i;
            end else dead_d = dead_q + 1'b1;
         endcase
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= W_OFF;
         dir_q  <= DIR_OFF;
         cur_q  <= '0;
         app_q  <= '0;
         dead_q <= '0;
      end else begin
         st_q   <= st_d;
         dir_q  <= dir_d;
         cur_q  <= cur_d;
         app_q  <= app_d;
         dead_q <= dead_d;
      end
   end
   assign in_o      = active ? dir_q : DIR_OFF;
   assign pwm_o     = active && (DUTY_W'(cnt_i) < app_q);
   assign settled_o = cur_q == tgt_duty_i && app_q == cur_q &&
                      (st_q == W_RUN ? dir_q == tgt_dir_i : st_q == W_OFF && tgt_dir_i == DIR_OFF);
endmodule

// File: rtl/motor_mode_driver.sv
// motor_mode_driver: decodes the registered FSM mode into per-wheel targets and drives PWM and H-bridge pins.
module motor_mode_driver
   import motor_pkg::*;
#(
   parameter int PWM_PERIOD = 1024,
   parameter int DUTY_W     = 11,
   parameter int RAMP_DIV   = 100000,
   parameter int RAMP_STEP  = 32,
   parameter int DEAD_CYC   = 50000,
   parameter int SPD_FAST   = 1000,
   parameter int SPD_SLOW   = 600,
   parameter int SPD_TURN   = 700
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] mode,
   output logic [1:0] pwm,
   output logic [1:0] l_IN,
   output logic [1:0] r_IN,
   output logic       settled
);
   localparam int CW = PWM_PERIOD > 1 ? $clog2(PWM_PERIOD) : 1;
   localparam int RW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
   logic [4:0] mode_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] div_q, div_d;
   logic wrap, tick, estop, l_set, r_set;
   dir_e l_dir, r_dir;
   logic [DUTY_W-1:0] l_duty, r_duty;
   assign wrap  = cnt_q == CW'(PWM_PERIOD - 1);
   assign tick  = div_q == RW'(RAMP_DIV - 1);
   assign estop = mode_q == M_ERROR;
   assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
   assign div_d = tick ? '0 : div_q + 1'b1;
   always_comb begin
      l_dir  = DIR_OFF;
      r_dir  = DIR_OFF;
      l_duty = '0;
      r_duty = '0;
      case (mode_q)
         M_STRAIGHT: begin
            l_dir = DIR_FWD; r_dir = DIR_FWD;
            l_duty = DUTY_W'(SPD_FAST); r_duty = DUTY_W'(SPD_FAST);
         end
         M_CHOOSE: begin
            l_dir = DIR_FWD; r_dir = DIR_FWD;
            l_duty = DUTY_W'(SPD_SLOW); r_duty = DUTY_W'(SPD_SLOW);
         end
         M_BACK: begin
            l_dir = DIR_REV; r_dir = DIR_REV;
            l_duty = DUTY_W'(SPD_SLOW); r_duty = DUTY_W'(SPD_SLOW);
         end
         M_TURN_L: begin
            l_dir = DIR_REV; r_dir = DIR_FWD;
            l_duty = DUTY_W'(SPD_TURN); r_duty = DUTY_W'(SPD_TURN);
         end
         M_TURN_R: begin
            l_dir = DIR_FWD; r_dir = DIR_REV;
            l_duty = DUTY_W'(SPD_TURN); r_duty = DUTY_W'(SPD_TURN);
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= '0;
         cnt_q  <= '0;
         div_q  <= '0;
      end else begin
         mode_q <= mode;
         cnt_q  <= cnt_d;
         div_q  <= div_d;
      end
   end
   wheel_channel #(
      .DUTY_W(DUTY_W), .PWM_PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC), .CW(CW)
   ) u_left (
      .clk(clk), .rst(rst), .tick_i(tick), .wrap_i(wrap), .estop_i(estop), .cnt_i(cnt_q),
      .tgt_dir_i(l_dir), .tgt_duty_i(l_duty), .pwm_o(pwm[1]), .in_o(l_IN), .settled_o(l_set)
   );
   wheel_channel #(
      .DUTY_W(DUTY_W), .PWM_PERIOD(PWM_PERIOD), .RAMP_STEP(RAMP_STEP), .DEAD_CYC(DEAD_CYC), .CW(CW)
   ) u_right (
      .clk(clk), .rst(rst), .tick_i(tick), .wrap_i(wrap), .estop_i(estop), .cnt_i(cnt_q),
      .tgt_dir_i(r_dir), .tgt_duty_i(r_duty), .pwm_o(pwm[0]), .in_o(r_IN), .settled_o(r_set)
   );
   assign settled = l_set && r_set;
endmodule

// File: tb/tb_motor_mode_driver.sv
// tb_motor_mode_driver: directed table of steady-state mode checks plus hand-timed ramp, dead-time and stop sequences.
module tb_motor_mode_driver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] mode = 5'd0;
   logic [1:0] pwm, l_IN, r_IN, pl, pr;
   logic settled;
   logic mon_en = 1'b0;
   int errors = 0;
   int checks = 0;
   typedef struct {
      logic [4:0] mode;
      logic [1:0] l_in;
      logic [1:0] r_in;
      logic       st;
      int         lh;
      int         rh;
   } vec_t;
   vec_t tbl[12];
   always #5 clk = ~clk;
   motor_mode_driver #(
      .PWM_PERIOD(16), .DUTY_W(11), .RAMP_DIV(4), .RAMP_STEP(4), .DEAD_CYC(8),
      .SPD_FAST(16), .SPD_SLOW(8), .SPD_TURN(12)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .pwm(pwm), .l_IN(l_IN), .r_IN(r_IN), .settled(settled)
   );
   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask
   task automatic count_hi(output int lh, output int rh);
      lh = 0;
      rh = 0;
      repeat (16) begin
         @(negedge clk);
         lh += int'(pwm[1]);
         rh += int'(pwm[0]);
      end
   endtask
   // Bridge safety invariants watched every cycle once the start-up sequence is done.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ((pl == 2'b10 && l_IN == 2'b01) || (pl == 2'b01 && l_IN == 2'b10) ||
             (pr == 2'b10 && r_IN == 2'b01) || (pr == 2'b01 && r_IN == 2'b10)) begin
            errors++;
            $display("FAIL dir_switch: got l=%b r=%b after l=%b r=%b, required a 00 gap", l_IN, r_IN, pl, pr);
         end
         checks++;
         if ((l_IN == 2'b00 && pwm[1]) || (r_IN == 2'b00 && pwm[0])) begin
            errors++;
            $display("FAIL pwm_no_dir: got pwm=%b with l=%b r=%b, required pwm 0 on an off bridge", pwm, l_IN, r_IN);
         end
      end
      pl <= l_IN;
      pr <= r_IN;
   end
   initial begin
      int lh, rh, hi, zl, zr, bad;
      tbl[0]  = '{5'd3,  2'b10, 2'b10, 1'b1, 16, 16};
      tbl[1]  = '{5'd4,  2'b10, 2'b10, 1'b1, 8,  8};
      tbl[2]  = '{5'd7,  2'b01, 2'b01, 1'b1, 8,  8};
      tbl[3]  = '{5'd5,  2'b01, 2'b10, 1'b1, 12, 12};
      tbl[4]  = '{5'd6,  2'b10, 2'b01, 1'b1, 12, 12};
      tbl[5]  = '{5'd0,  2'b00, 2'b00, 1'b1, 0,  0};
      tbl[6]  = '{5'd3,  2'b10, 2'b10, 1'b1, 16, 16};
      tbl[7]  = '{5'd30, 2'b00, 2'b00, 1'b1, 0,  0};
      tbl[8]  = '{5'd9,  2'b00, 2'b00, 1'b1, 0,  0};
      tbl[9]  = '{5'd6,  2'b10, 2'b01, 1'b1, 12, 12};
      tbl[10] = '{5'd31, 2'b00, 2'b00, 1'b1, 0,  0};
      tbl[11] = '{5'd3,  2'b10, 2'b10, 1'b1, 16, 16};
      repeat (3) @(negedge clk);
      check("rst_pwm", pwm, 0);
      check("rst_l_in", l_IN, 0);
      check("rst_r_in", r_IN, 0);
      check("rst_settled", settled, 1);
      rst = 1'b0;
      mode = 5'd3;
      @(negedge clk);
      check("start_lat1_l", l_IN, 0);
      @(negedge clk);
      check("start_lat2_l", l_IN, 2);
      check("start_lat2_r", r_IN, 2);
      check("start_unsettled", settled, 0);
      hi = 0;
      repeat (13) begin
         @(negedge clk);
         hi += int'(pwm[1]) + int'(pwm[0]);
      end
      check("start_pwm_off", hi, 0);
      count_hi(lh, rh);
      check("ramp_l_duty12", lh, 12);
      check("ramp_r_duty12", rh, 12);
      check("ramp_not_settled", settled, 0);
      @(negedge clk);
      check("ramp_settled", settled, 1);
      count_hi(lh, rh);
      check("ramp_l_duty16", lh, 16);
      check("ramp_r_duty16", rh, 16);
      mon_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         mode = tbl[i].mode;
         repeat (100) @(negedge clk);
         check($sformatf("row%0d_l_in", i), l_IN, tbl[i].l_in);
         check($sformatf("row%0d_r_in", i), r_IN, tbl[i].r_in);
         check($sformatf("row%0d_settled", i), settled, tbl[i].st);
         count_hi(lh, rh);
         check($sformatf("row%0d_l_duty", i), lh, tbl[i].lh);
         check($sformatf("row%0d_r_duty", i), rh, tbl[i].rh);
      end
      mode = 5'd7;
      zl = 0;
      zr = 0;
      repeat (150) begin
         @(negedge clk);
         zl += int'(l_IN == 2'b00);
         zr += int'(r_IN == 2'b00);
      end
      check("rev_dead_l", zl, 8);
      check("rev_dead_r", zr, 8);
      check("rev_l_in", l_IN, 1);
      check("rev_r_in", r_IN, 1);
      mode = 5'd3;
      repeat (100) @(negedge clk);
      mode = 5'd5;
      zl = 0;
      zr = 0;
      repeat (150) begin
         @(negedge clk);
         zl += int'(l_IN == 2'b00);
         zr += int'(r_IN == 2'b00);
      end
      check("turn_dead_l", zl, 8);
      check("turn_dead_r", zr, 0);
      check("turn_l_in", l_IN, 1);
      check("turn_r_in", r_IN, 2);
      count_hi(lh, rh);
      check("turn_l_duty", lh, 12);
      check("turn_r_duty", rh, 12);
      mode = 5'd3;
      repeat (100) @(negedge clk);
      check("estop_pre_pwm", pwm, 3);
      mode = 5'd31;
      @(negedge clk);
      @(negedge clk);
      check("estop_pwm", pwm, 0);
      check("estop_l_in", l_IN, 0);
      check("estop_r_in", r_IN, 0);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         bad += int'(pwm != 2'b00) + int'(l_IN != 2'b00) + int'(r_IN != 2'b00);
      end
      check("estop_hold", bad, 0);
      mode = 5'd3;
      @(negedge clk);
      check("restart_lat1_l", l_IN, 0);
      @(negedge clk);
      check("restart_lat2_l", l_IN, 2);
      check("restart_from_zero", settled, 0);
      repeat (100) @(negedge clk);
      mode = 5'd7;
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         bad += int'(l_IN != 2'b10) + int'(r_IN != 2'b10);
      end
      mode = 5'd3;
      repeat (80) begin
         @(negedge clk);
         bad += int'(l_IN != 2'b10) + int'(r_IN != 2'b10);
      end
      check("revert_in_fwd", bad, 0);
      check("revert_settled", settled, 1);
      count_hi(lh, rh);
      check("revert_l_duty", lh, 16);
      check("revert_r_duty", rh, 16);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
